sdram_port_scheduler: RTL and testbench
=======================================

// Module: sdram_port_scheduler
// PURPOSE
//  Schedules the SDRAM frame buffer between four FIFO ports (0=WR1 camera G/B, 1=WR2 camera G/R, 2=RD1 VGA, 3=RD2 VGA)
//  and the refresh timer. Tracks per-port burst addresses with wrap and issues one burst command at a time to the
//  SDRAM command engine. Sits between the port FIFOs and the command engine inside the SDRAM controller.
// PARAMETERS
//  ADDR_W  23  SDRAM word address width
//  LEN_W   8   burst length width (codebase uses 8'h50)
//  USED_W  10  FIFO used-words width
// PORTS
//  iCLK        in   1           controller clock (sdram_ctrl_clk)
//  iRST        in   1           asynchronous reset, active-high
//  iUSEDW      in   4*USED_W    per-port FIFO fill level, port p at [p*USED_W +: USED_W]
//  iBASE_ADDR  in   4*ADDR_W    per-port start address
//  iMAX_ADDR   in   4*ADDR_W    per-port end address (exclusive)
//  iLENGTH     in   4*LEN_W     per-port burst length, nonzero
//  iLOAD       in   4           per-port: reload address from iBASE_ADDR
//  iREF_REQ    in   1           refresh request level, held until served
//  iCMD_READY  in   1           command engine accepts oCMD_*
//  iCMD_DONE   in   1           one-cycle pulse: current burst/refresh finished
//  oCMD_VALID  out  1           burst command valid
//  oCMD_WRITE  out  1           1=write burst (ports 0,1), 0=read burst (ports 2,3)
//  oCMD_PORT   out  2           port of current command
//  oCMD_ADDR   out  ADDR_W      burst start address
//  oCMD_LEN    out  LEN_W       burst length
//  oREF_GRANT  out  1           refresh owns SDRAM
//  oBUSY       out  1           state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all port addresses 0, round-robin pointers to port 0 (write) and port 2 (read).
//  Request: write port p requests when usedw[p] >= len[p]; read port p requests when usedw[p] < len[p].
//  Priority in IDLE: refresh > read ports (RR between 2,3) > write ports (RR between 0,1). After a grant, the RR
//   pointer of that tier moves to the other port of the tier.
//  FSM: IDLE -> REF if iREF_REQ (oREF_GRANT=1 next cycle, held until iCMD_DONE, then IDLE).
//       IDLE -> ISSUE on a winner: oCMD_* registered the next cycle; oCMD_VALID and fields stay stable until the
//       cycle iCMD_READY=1. ISSUE -> BUSY on iCMD_READY (oCMD_VALID drops next cycle). BUSY -> IDLE on iCMD_DONE.
//  Latency: request or refresh level sampled in IDLE -> output asserted on the next edge. Min burst turnaround is
//   3 cycles (IDLE, ISSUE, BUSY) plus engine time.
//  Refresh does not preempt ISSUE/BUSY; it is served at the next IDLE ahead of all ports.
//  Address update on iCMD_DONE in BUSY: nxt = addr + len; if nxt >= max, addr = base, else addr = nxt.
//   Arithmetic is ADDR_W+1 bits wide, so no overflow at the top of the address space.
//  iLOAD[p] in any state: addr[p] = base[p] next cycle and beats a same-cycle DONE update for p.
//   If p is in ISSUE, oCMD_ADDR is not changed; the command in flight completes with its old address.
//  iCMD_DONE outside BUSY/REF is ignored. iCMD_READY outside ISSUE is ignored.
//  iRST mid-burst: immediate return to reset state. The engine is reset by the same iRST.
// TESTING
//  1 Reset, LOAD all ports, usedw[0]=0x50, len=0x50 -> ISSUE port0 write at addr 0x000000; after DONE, addr0=0x50.
//  2 Ports 2,3 usedw=0 and port0 full in the same cycle -> grant order 2,3,2,3... while reads request; port0 only when
//    reads are satisfied.
//  3 iREF_REQ rises during BUSY -> no oREF_GRANT until DONE; then REF granted before pending port 1 write.
//  4 Port1 base=0x100000, max=0x100000+640*480, addr=max-0x50 -> after DONE addr=0x100000 (wrap); at max-0x20 with
//    len 0x50 -> also wraps.
//  5 iLOAD[0] same cycle as DONE for port0 at addr 0x1000 -> addr0=base (0), not 0x1050.
//  6 iCMD_READY held 0 for 5 cycles in ISSUE -> oCMD_VALID/ADDR/LEN constant; iRST pulse there -> all outputs 0 next edge.

Source files
------------

// File: rtl/sdram_port_scheduler.sv
// Arbitrates the SDRAM between refresh, two read ports and two write ports, tracking
// per-port burst addresses with wrap and issuing one burst command at a time.
module sdram_port_scheduler #(
    parameter int ADDR_W = 23,
    parameter int LEN_W  = 8,
    parameter int USED_W = 10
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [4*USED_W-1:0]   iUSEDW,
    input  logic [4*ADDR_W-1:0]   iBASE_ADDR,
    input  logic [4*ADDR_W-1:0]   iMAX_ADDR,
    input  logic [4*LEN_W-1:0]    iLENGTH,
    input  logic [3:0]            iLOAD,
    input  logic                  iREF_REQ,
    input  logic                  iCMD_READY,
    input  logic                  iCMD_DONE,
    output logic                  oCMD_VALID,
    output logic                  oCMD_WRITE,
    output logic [1:0]            oCMD_PORT,
    output logic [ADDR_W-1:0]     oCMD_ADDR,
    output logic [LEN_W-1:0]      oCMD_LEN,
    output logic                  oREF_GRANT,
    output logic                  oBUSY
);

    typedef enum logic [1:0] {StIdle, StRef, StIssue, StBusy} state_e;

    state_e state_q, state_d;

    logic [USED_W-1:0] usedw_a [4];
    logic [ADDR_W-1:0] base_a  [4];
    logic [ADDR_W-1:0] max_a   [4];
    logic [LEN_W-1:0]  len_a   [4];

    logic [ADDR_W-1:0] addr_q [4];
    logic [ADDR_W-1:0] addr_d [4];
    logic [ADDR_W:0]   nxt_a  [4];

    logic rr_rd_q, rr_rd_d;
    logic rr_wr_q, rr_wr_d;

    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_write_q, cmd_write_d;
    logic [1:0]        cmd_port_q, cmd_port_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
    logic              ref_grant_q, ref_grant_d;
    logic              upd_en;

    logic [3:0] req;
    logic [1:0] rd_req, wr_req;
    logic       rd_sel, wr_sel;
    logic [1:0] win_port;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            usedw_a[p] = iUSEDW[p*USED_W +: USED_W];
            base_a[p]  = iBASE_ADDR[p*ADDR_W +: ADDR_W];
            max_a[p]   = iMAX_ADDR[p*ADDR_W +: ADDR_W];
            len_a[p]   = iLENGTH[p*LEN_W +: LEN_W];
        end
    end

    // Write ports want service once a full burst is buffered; read ports once they can take one.
    always_comb begin
        req = '0;
        for (int p = 0; p < 4; p++) begin
            if (p < 2) begin
                req[p] = 32'(usedw_a[p]) >= 32'(len_a[p]);
            end else begin
                req[p] = 32'(usedw_a[p]) < 32'(len_a[p]);
            end
        end
    end

    always_comb begin
        rd_req   = req[3:2];
        wr_req   = req[1:0];
        rd_sel   = (rd_req == 2'b11) ? rr_rd_q : rd_req[1];
        wr_sel   = (wr_req == 2'b11) ? rr_wr_q : wr_req[1];
        win_port = (|rd_req) ? {1'b1, rd_sel} : {1'b0, wr_sel};
    end

    always_comb begin
        state_d     = state_q;
        rr_rd_d     = rr_rd_q;
        rr_wr_d     = rr_wr_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_port_d  = cmd_port_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        ref_grant_d = ref_grant_q;
        upd_en      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (iREF_REQ) begin
                    state_d     = StRef;
                    ref_grant_d = 1'b1;
                end else if (|req) begin
                    state_d     = StIssue;
                    cmd_valid_d = 1'b1;
                    cmd_write_d = ~(|rd_req);
                    cmd_port_d  = win_port;
                    cmd_addr_d  = addr_q[win_port];
                    cmd_len_d   = len_a[win_port];
                    if (|rd_req) begin
                        rr_rd_d = ~rd_sel;
                    end else begin
                        rr_wr_d = ~wr_sel;
                    end
                end
            end
            StIssue: begin
                if (iCMD_READY) begin
                    state_d     = StBusy;
                    cmd_valid_d = 1'b0;
                end
            end
            StBusy: begin
                if (iCMD_DONE) begin
                    state_d = StIdle;
                    upd_en  = 1'b1;
                end
            end
            StRef: begin
                if (iCMD_DONE) begin
                    state_d     = StIdle;
                    ref_grant_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // One extra bit keeps addr + len from overflowing at the top of the address space.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            nxt_a[p]  = {1'b0, addr_q[p]} + (ADDR_W+1)'(cmd_len_q);
            addr_d[p] = addr_q[p];
            if (upd_en && (cmd_port_q == 2'(p))) begin
                if (nxt_a[p] >= {1'b0, max_a[p]}) begin
                    addr_d[p] = base_a[p];
                end else begin
                    addr_d[p] = nxt_a[p][ADDR_W-1:0];
                end
            end
            if (iLOAD[p]) begin
                addr_d[p] = base_a[p];
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= StIdle;
            rr_rd_q     <= 1'b0;
            rr_wr_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_port_q  <= 2'd0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            ref_grant_q <= 1'b0;
            for (int p = 0; p < 4; p++) begin
                addr_q[p] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_rd_q     <= rr_rd_d;
            rr_wr_q     <= rr_wr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_port_q  <= cmd_port_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            ref_grant_q <= ref_grant_d;
            for (int p = 0; p < 4; p++) begin
                addr_q[p] <= addr_d[p];
            end
        end
    end

    assign oCMD_VALID = cmd_valid_q;
    assign oCMD_WRITE = cmd_write_q;
    assign oCMD_PORT  = cmd_port_q;
    assign oCMD_ADDR  = cmd_addr_q;
    assign oCMD_LEN   = cmd_len_q;
    assign oREF_GRANT = ref_grant_q;
    assign oBUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed plus randomized bench for sdram_port_scheduler against a transaction-level model
// of the arbitration and address-wrap rules.
module tb_sdram_port_scheduler;
    localparam int ADDR_W = 23;
    localparam int LEN_W  = 8;
    localparam int USED_W = 10;
    localparam int FRAME  = 640 * 480;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [USED_W-1:0] usedw [4];
    logic [ADDR_W-1:0] base  [4];
    logic [ADDR_W-1:0] maxa  [4];
    logic [LEN_W-1:0]  len   [4];
    logic [3:0]        load;
    logic              ref_req, ready, done;

    logic [4*USED_W-1:0] usedw_v;
    logic [4*ADDR_W-1:0] base_v, max_v;
    logic [4*LEN_W-1:0]  len_v;

    logic              cmd_valid, cmd_write, ref_grant, busy;
    logic [1:0]        cmd_port;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    always_comb begin
        usedw_v = '0;
        base_v  = '0;
        max_v   = '0;
        len_v   = '0;
        for (int p = 0; p < 4; p++) begin
            usedw_v[p*USED_W +: USED_W] = usedw[p];
            base_v[p*ADDR_W +: ADDR_W]  = base[p];
            max_v[p*ADDR_W +: ADDR_W]   = maxa[p];
            len_v[p*LEN_W +: LEN_W]     = len[p];
        end
    end

    sdram_port_scheduler #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .USED_W(USED_W)) dut (
        .iCLK(clk), .iRST(rst), .iUSEDW(usedw_v), .iBASE_ADDR(base_v), .iMAX_ADDR(max_v),
        .iLENGTH(len_v), .iLOAD(load), .iREF_REQ(ref_req), .iCMD_READY(ready),
        .iCMD_DONE(done), .oCMD_VALID(cmd_valid), .oCMD_WRITE(cmd_write),
        .oCMD_PORT(cmd_port), .oCMD_ADDR(cmd_addr), .oCMD_LEN(cmd_len),
        .oREF_GRANT(ref_grant), .oBUSY(busy)
    );

    // Model: tracked address per port, and which port of each tier is preferred on a tie.
    logic [ADDR_W-1:0] m_addr [4];
    bit m_pref3, m_pref1;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++) m_addr[p] = '0;
        m_pref3 = 1'b0;
        m_pref1 = 1'b0;
    endtask

    // -1 = refresh, -2 = nothing, else granted port
    function automatic int predict();
        bit [3:0] rq;
        for (int p = 0; p < 4; p++)
            rq[p] = (p < 2) ? (int'(usedw[p]) >= int'(len[p])) : (int'(usedw[p]) < int'(len[p]));
        if (ref_req) return -1;
        if (rq[2] && rq[3]) return m_pref3 ? 3 : 2;
        if (rq[2]) return 2;
        if (rq[3]) return 3;
        if (rq[0] && rq[1]) return m_pref1 ? 1 : 0;
        if (rq[0]) return 0;
        if (rq[1]) return 1;
        return -2;
    endfunction

    task automatic quiet();
        usedw[0] = '0;
        usedw[1] = '0;
        usedw[2] = '1;
        usedw[3] = '1;
        ref_req  = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] mask);
        quiet();
        load = mask;
        step();
        load = '0;
        for (int p = 0; p < 4; p++) if (mask[p]) m_addr[p] = base[p];
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        step();
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_write", 32'(cmd_write), 32'd0);
        check("rst_port", 32'(cmd_port), 32'd0);
        check("rst_addr", 32'(cmd_addr), 32'd0);
        check("rst_len", 32'(cmd_len), 32'd0);
        check("rst_ref", 32'(ref_grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        model_reset();
        step();
    endtask

    task automatic run_txn(input bit ref_in_busy, input bit load_at_done, input int hold);
        int exp;
        logic [ADDR_W-1:0] ea;
        logic [LEN_W-1:0] el;
        longint nxt;
        exp = predict();
        step();
        if (exp == -1) begin
            check("ref_grant", 32'(ref_grant), 32'd1);
            check("ref_valid", 32'(cmd_valid), 32'd0);
            check("ref_busy", 32'(busy), 32'd1);
            repeat (hold) step();
            check("ref_hold", 32'(ref_grant), 32'd1);
            done = 1'b1;
            ref_req = 1'b0;
            step();
            done = 1'b0;
            check("ref_release", 32'(ref_grant), 32'd0);
            check("ref_idle", 32'(busy), 32'd0);
        end else if (exp >= 0) begin
            ea = m_addr[exp];
            el = len[exp];
            check("cmd_valid", 32'(cmd_valid), 32'd1);
            check("cmd_write", 32'(cmd_write), (exp < 2) ? 32'd1 : 32'd0);
            check("cmd_port", 32'(cmd_port), 32'(exp));
            check("cmd_addr", 32'(cmd_addr), 32'(ea));
            check("cmd_len", 32'(cmd_len), 32'(el));
            if (exp >= 2) m_pref3 = (exp == 2);
            else m_pref1 = (exp == 0);
            for (int i = 0; i < hold; i++) begin
                done = 1'(i % 2);
                step();
                check("hold_valid", 32'(cmd_valid), 32'd1);
                check("hold_addr", 32'(cmd_addr), 32'(ea));
                check("hold_len", 32'(cmd_len), 32'(el));
            end
            done = 1'b0;
            ready = 1'b1;
            step();
            ready = 1'b0;
            check("acc_valid", 32'(cmd_valid), 32'd0);
            check("acc_busy", 32'(busy), 32'd1);
            if (ref_in_busy) begin
                ref_req = 1'b1;
                repeat (2) step();
                check("busy_no_ref", 32'(ref_grant), 32'd0);
                check("busy_still", 32'(busy), 32'd1);
            end
            done = 1'b1;
            if (load_at_done) load[exp] = 1'b1;
            step();
            done = 1'b0;
            load = '0;
            check("done_idle", 32'(busy), 32'd0);
            check("done_ref", 32'(ref_grant), 32'd0);
            if (load_at_done) begin
                m_addr[exp] = base[exp];
            end else begin
                nxt = longint'(ea) + longint'(el);
                if (nxt >= longint'(maxa[exp])) m_addr[exp] = base[exp];
                else m_addr[exp] = ADDR_W'(nxt);
            end
        end else begin
            check("none_valid", 32'(cmd_valid), 32'd0);
            check("none_busy", 32'(busy), 32'd0);
            done = 1'b1;
            ready = 1'b1;
            step();
            done = 1'b0;
            ready = 1'b0;
            check("stray_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        load = '0;
        ready = 1'b0;
        done = 1'b0;
        for (int p = 0; p < 4; p++) begin
            base[p] = ADDR_W'(p * 32'h100000);
            maxa[p] = ADDR_W'(p * 32'h100000 + FRAME);
            len[p]  = 8'h50;
        end
        quiet();
        model_reset();

        // Single write burst, then the address advances by one burst
        do_reset();
        do_load(4'hF);
        usedw[0] = 10'h50;
        run_txn(1'b0, 1'b0, 2);
        run_txn(1'b0, 1'b0, 0);

        // Both read ports starving alongside a full write port
        usedw[2] = '0;
        usedw[3] = '0;
        repeat (4) run_txn(1'b0, 1'b0, 1);
        usedw[2] = '1;
        usedw[3] = '1;
        run_txn(1'b0, 1'b0, 0);

        // Refresh raised mid-burst waits, then beats the pending port-1 write
        quiet();
        usedw[1] = 10'h50;
        run_txn(1'b1, 1'b0, 1);
        run_txn(1'b0, 1'b0, 2);
        run_txn(1'b0, 1'b0, 0);

        // Wrap at the frame end: exactly one burst short, and a partial burst short
        base[1] = maxa[1] - 23'h50;
        do_load(4'h2);
        base[1] = 23'h100000;
        usedw[1] = 10'h50;
        run_txn(1'b0, 1'b0, 0);
        run_txn(1'b0, 1'b0, 0);
        base[1] = maxa[1] - 23'h20;
        do_load(4'h2);
        base[1] = 23'h100000;
        usedw[1] = 10'h50;
        run_txn(1'b0, 1'b0, 0);
        run_txn(1'b0, 1'b0, 0);

        // LOAD coinciding with DONE wins over the increment
        base[0] = 23'h1000;
        do_load(4'h1);
        base[0] = '0;
        usedw[0] = 10'h50;
        run_txn(1'b0, 1'b1, 0);
        run_txn(1'b0, 1'b0, 0);

        // Stalled ISSUE keeps the command stable; reset there clears everything
        quiet();
        usedw[0] = 10'h50;
        step();
        check("stall_valid", 32'(cmd_valid), 32'd1);
        check("stall_addr0", 32'(cmd_addr), 32'(m_addr[0]));
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_hold", 32'(cmd_valid), 32'd1);
            check("stall_addr", 32'(cmd_addr), 32'(m_addr[0]));
            check("stall_len", 32'(cmd_len), 32'h50);
        end
        do_reset();

        // Randomized traffic with small windows so wraps are frequent
        for (int p = 0; p < 4; p++) maxa[p] = base[p] + ADDR_W'($urandom_range(32'h100, 32'h400));
        do_load(4'hF);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) do_load(4'($urandom_range(1, 15)));
            for (int p = 0; p < 4; p++) begin
                len[p] = 8'($urandom_range(1, 255));
                usedw[p] = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 1023))
                                                        : 10'($urandom_range(0, 255));
            end
            if (!ref_req) ref_req = ($urandom_range(0, 4) == 0);
            run_txn($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
